// File: rtl/ranger_pkg.sv
// ============================================================================
// Module  : ranger_pkg
// Brief   : Shared FSM state type and default timing for ultrasonic_ranger.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ranger_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    DRAIN     = 3'd4
  } state_t;

  // 12 MHz clock: 10 us trigger, 60 ms ping period, 30 ms echo limit
  localparam int unsigned C_CW             = 32;
  localparam int unsigned C_TRIG_CYCLES    = 120;
  localparam int unsigned C_PERIOD_CYCLES  = 720000;
  localparam int unsigned C_TIMEOUT_CYCLES = 360000;

endpackage

`default_nettype wire

// File: rtl/median3.sv
// ============================================================================
// Module  : median3
// Brief   : 3-deep result window with combinational median; the newest entry
//           passes straight through until the window holds three results.
//           Only present when ULTRASONIC_RANGER_MEDIAN3_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef ULTRASONIC_RANGER_MEDIAN3_EN
module median3 #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] r_win0;
  logic [W-1:0] r_win1;
  logic [W-1:0] r_win2;
  logic [1:0]   r_fill;

  function automatic logic [W-1:0] med3(input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [W-1:0] mid;
    lo  = (a < b) ? a : b;
    hi  = (a < b) ? b : a;
    mid = (hi < c) ? hi : c;
    return (lo > mid) ? lo : mid;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win0 <= '0;
      r_win1 <= '0;
      r_win2 <= '0;
      r_fill <= 2'd0;
    end else if (push) begin
      r_win0 <= din;
      r_win1 <= r_win0;
      r_win2 <= r_win1;
      if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
    end
  end

  assign dout = (r_fill == 2'd3) ? med3(r_win0, r_win1, r_win2) : r_win0;

endmodule
`endif

`default_nettype wire

// File: rtl/ultrasonic_ranger.sv
// ============================================================================
// Module  : ultrasonic_ranger
// Brief   : HC-SR04 ranging controller: periodic trig, synchronised echo width
//           measurement with timeouts. Define ULTRASONIC_RANGER_MEDIAN3_EN to
//           median-filter the reported widths.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ultrasonic_ranger
  import ranger_pkg::*;
#(
  parameter int unsigned CW             = C_CW,
  parameter int unsigned TRIG_CYCLES    = C_TRIG_CYCLES,
  parameter int unsigned PERIOD_CYCLES  = C_PERIOD_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = C_TIMEOUT_CYCLES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          echo,
  output logic          trig,
  output logic [CW-1:0] echo_cycles,
  output logic          valid,
  output logic          timeout,
  output logic          busy
);

  localparam int unsigned C_PW = $clog2(PERIOD_CYCLES);
  localparam int unsigned C_TW = $clog2(TRIG_CYCLES + 1);
  localparam int unsigned C_MW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [C_PW-1:0] C_PERIOD_LAST = C_PW'(PERIOD_CYCLES - 1);
  localparam logic [C_TW-1:0] C_TRIG_LAST   = C_TW'(TRIG_CYCLES - 1);
  localparam logic [C_MW-1:0] C_WAIT_LAST   = C_MW'(TIMEOUT_CYCLES - 1);
  localparam logic [C_MW-1:0] C_MEAS_MAX    = C_MW'(TIMEOUT_CYCLES);

  state_t          r_state;
  logic [C_PW-1:0] r_pcnt;
  logic [C_TW-1:0] r_tcnt;
  logic [C_MW-1:0] r_cnt;
  logic            r_echo_meta;
  logic            r_echo_s;
  logic            r_echo_d;
  logic            w_rise;
  logic            w_fall;
  logic            w_period_done;
  logic [CW-1:0]   w_cnt_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_echo_meta <= 1'b0;
      r_echo_s    <= 1'b0;
      r_echo_d    <= 1'b0;
    end else begin
      r_echo_meta <= echo;
      r_echo_s    <= r_echo_meta;
      r_echo_d    <= r_echo_s;
    end
  end

  assign w_rise        = r_echo_s & ~r_echo_d;
  assign w_fall        = ~r_echo_s & r_echo_d;
  assign w_period_done = (r_pcnt == C_PERIOD_LAST);
  assign w_cnt_ext     = CW'(r_cnt);

`ifdef ULTRASONIC_RANGER_MEDIAN3_EN
  logic          r_med_pend;
  logic          w_push;
  logic [CW-1:0] w_med;

  assign w_push = (r_state == MEASURE) && w_fall;

  median3 #(.W(CW)) u_median3 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (w_cnt_ext),
    .dout  (w_med)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pcnt      <= C_PERIOD_LAST;
      r_tcnt      <= '0;
      r_cnt       <= '0;
      trig        <= 1'b0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      timeout     <= 1'b0;
      echo_cycles <= '0;
`ifdef ULTRASONIC_RANGER_MEDIAN3_EN
      r_med_pend  <= 1'b0;
`endif
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      if (!w_period_done) r_pcnt <= r_pcnt + 1'b1;
`ifdef ULTRASONIC_RANGER_MEDIAN3_EN
      // The window shifts on the fall edge; its median is ready one cycle later
      r_med_pend <= 1'b0;
      if (r_med_pend) begin
        echo_cycles <= w_med;
        valid       <= 1'b1;
      end
`endif
      case (r_state)
        IDLE: begin
          if (w_period_done) begin
            r_state <= TRIG;
            trig    <= 1'b1;
            busy    <= 1'b1;
            r_pcnt  <= '0;
            r_tcnt  <= '0;
          end
        end
        TRIG: begin
          if (r_tcnt == C_TRIG_LAST) begin
            trig    <= 1'b0;
            r_cnt   <= '0;
            r_state <= WAIT_RISE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        WAIT_RISE: begin
          if (w_rise) begin
            r_cnt   <= C_MW'(1);
            r_state <= MEASURE;
          end else if (r_cnt == C_WAIT_LAST) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        MEASURE: begin
          if (w_fall) begin
`ifdef ULTRASONIC_RANGER_MEDIAN3_EN
            r_med_pend  <= 1'b1;
`else
            echo_cycles <= w_cnt_ext;
            valid       <= 1'b1;
`endif
            busy    <= 1'b0;
            r_state <= IDLE;
          end else if (r_cnt == C_MEAS_MAX) begin
            timeout <= 1'b1;
            r_state <= DRAIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (!r_echo_s) begin
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ultrasonic_ranger.sv
// ============================================================================
// Module  : tb_ultrasonic_ranger
// Brief   : Directed self-checking bench for ultrasonic_ranger (short timing).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ultrasonic_ranger;

  localparam int CW     = 32;
  localparam int TRIG   = 4;
  localparam int PERIOD = 200;
  localparam int TMO    = 100;
`ifdef ULTRASONIC_RANGER_MEDIAN3_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          echo = 1'b0;
  logic          trig;
  logic [CW-1:0] echo_cycles;
  logic          valid;
  logic          timeout;
  logic          busy;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int start = 0;

  always #5 clk = ~clk;

  ultrasonic_ranger #(
    .CW             (CW),
    .TRIG_CYCLES    (TRIG),
    .PERIOD_CYCLES  (PERIOD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .echo        (echo),
    .trig        (trig),
    .echo_cycles (echo_cycles),
    .valid       (valid),
    .timeout     (timeout),
    .busy        (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Steps until trig rises; gap is measured from the previous trig rise.
  task automatic wait_trig(output bit found, output int gap);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (trig === 1'b1) found = 1'b1;
    end
    gap   = cyc - start;
    start = cyc;
  endtask

  // Called at the trig-rise cycle; echo rises 10 cycles after trig falls.
  task automatic run_ping(input int width, output bit got_v, output bit got_t,
                          output int lat, output logic [CW-1:0] val);
    repeat (13) step();
    echo = 1'b1;
    repeat (width) step();
    echo = 1'b0;
    got_v = 1'b0;
    got_t = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 20 && !(got_v || got_t); i++) begin
      step();
      lat   = i;
      got_v = valid;
      got_t = timeout;
    end
    val = echo_cycles;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) step();
    n_vec++; if (trig !== 1'b0)  begin n_bad++; $display("FAIL reset_trig: got %b want 0", trig); end
    n_vec++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_vec++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    n_vec++; if (echo_cycles !== '0) begin n_bad++; $display("FAIL reset_cycles: got %0d want 0", echo_cycles); end
    rst_n = 1'b1;
    step();
    start = cyc;
    n_vec++; if (trig !== 1'b1) begin n_bad++; $display("FAIL first_trig: got %b want 1", trig); end
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL first_busy: got %b want 1", busy); end
  endtask

  task automatic test_trig_timing();
    bit found;
    int gap;
    for (int k = 2; k <= TRIG; k++) begin
      step();
      n_vec++; if (trig !== 1'b1) begin n_bad++; $display("FAIL trig_high_%0d: got %b want 1", k, trig); end
    end
    step();
    n_vec++; if (trig !== 1'b0) begin n_bad++; $display("FAIL trig_fall: got %b want 0", trig); end
    wait_trig(found, gap);
    n_vec++; if (!found || gap != PERIOD) begin n_bad++; $display("FAIL trig_period: got %0d want %0d", gap, PERIOD); end
  endtask

  task automatic test_echo();
    bit gv, gt, found;
    int lat, gap;
    logic [CW-1:0] val;
    run_ping(25, gv, gt, lat, val);
    n_vec++; if (gv !== 1'b1 || gt !== 1'b0) begin n_bad++; $display("FAIL echo25_flags: got valid=%b timeout=%b want 1/0", gv, gt); end
    n_vec++; if (val !== 32'd25) begin n_bad++; $display("FAIL echo25_width: got %0d want 25", val); end
    n_vec++; if (lat != LAT) begin n_bad++; $display("FAIL echo25_latency: got %0d want %0d", lat, LAT); end
    step();
    n_vec++; if (valid !== 1'b0) begin n_bad++; $display("FAIL echo25_strobe: got %b want 0", valid); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL echo25_busy: got %b want 0", busy); end
    wait_trig(found, gap);
    n_vec++; if (!found || gap != PERIOD) begin n_bad++; $display("FAIL echo25_period: got %0d want %0d", gap, PERIOD); end
  endtask

  task automatic test_no_echo();
    bit found, saw_v;
    int gap, at;
    at = 0;
    saw_v = 1'b0;
    for (int i = 0; i < 300 && at == 0; i++) begin
      step();
      if (valid === 1'b1) saw_v = 1'b1;
      if (timeout === 1'b1) at = cyc - start + 1;
    end
    n_vec++; if (at != 5 + TMO) begin n_bad++; $display("FAIL noecho_timeout_at: got %0d want %0d", at, 5 + TMO); end
    n_vec++; if (saw_v) begin n_bad++; $display("FAIL noecho_valid: got 1 want 0"); end
    n_vec++; if (echo_cycles !== 32'd25) begin n_bad++; $display("FAIL noecho_hold: got %0d want 25", echo_cycles); end
    step();
    n_vec++; if (timeout !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL noecho_after: got timeout=%b busy=%b want 0/0", timeout, busy); end
    wait_trig(found, gap);
    n_vec++; if (!found || gap != PERIOD) begin n_bad++; $display("FAIL noecho_period: got %0d want %0d", gap, PERIOD); end
  endtask

  task automatic test_long_echo();
    bit found, saw_v;
    int gap, at;
    at = 0;
    saw_v = 1'b0;
    repeat (13) step();
    echo = 1'b1;
    repeat (150) begin
      step();
      if (valid === 1'b1) saw_v = 1'b1;
      if (timeout === 1'b1 && at == 0) at = cyc - start + 1;
    end
    echo = 1'b0;
    n_vec++; if (at != 117) begin n_bad++; $display("FAIL long_timeout_at: got %0d want 117", at); end
    n_vec++; if (echo_cycles !== 32'd25) begin n_bad++; $display("FAIL long_hold: got %0d want 25", echo_cycles); end
    repeat (2) begin step(); if (valid === 1'b1) saw_v = 1'b1; end
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL long_drain_busy: got %b want 1", busy); end
    step();
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL long_idle_busy: got %b want 0", busy); end
    n_vec++; if (saw_v || valid === 1'b1) begin n_bad++; $display("FAIL long_valid: got 1 want 0"); end
    wait_trig(found, gap);
    n_vec++; if (!found || gap != PERIOD) begin n_bad++; $display("FAIL long_period: got %0d want %0d", gap, PERIOD); end
  endtask

  task automatic test_reset_mid();
    bit gv, gt;
    int lat;
    logic [CW-1:0] val;
    repeat (13) step();
    echo = 1'b1;
    repeat (15) step();
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_pre_busy: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (trig !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_flags: got trig=%b valid=%b busy=%b want 0/0/0", trig, valid, busy);
    end
    n_vec++; if (echo_cycles !== '0) begin n_bad++; $display("FAIL mid_reset_cycles: got %0d want 0", echo_cycles); end
    echo = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    start = cyc;
    n_vec++; if (trig !== 1'b1) begin n_bad++; $display("FAIL mid_restart_trig: got %b want 1", trig); end
    run_ping(25, gv, gt, lat, val);
    n_vec++; if (gv !== 1'b1 || val !== 32'd25) begin n_bad++; $display("FAIL mid_clean_ping: got valid=%b width=%0d want 1/25", gv, val); end
  endtask

`ifdef ULTRASONIC_RANGER_MEDIAN3_EN
  task automatic test_median();
    int widths [4] = '{20, 90, 22, 95};
    int expect_w [4] = '{20, 90, 22, 90};
    bit gv, gt, found;
    int lat, gap;
    logic [CW-1:0] val;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    start = cyc;
    for (int i = 0; i < 4; i++) begin
      run_ping(widths[i], gv, gt, lat, val);
      n_vec++; if (gv !== 1'b1 || val !== CW'(expect_w[i])) begin
        n_bad++; $display("FAIL median_%0d: got valid=%b width=%0d want 1/%0d", i, gv, val, expect_w[i]);
      end
      n_vec++; if (lat != LAT) begin n_bad++; $display("FAIL median_lat_%0d: got %0d want %0d", i, lat, LAT); end
      wait_trig(found, gap);
      n_vec++; if (!found) begin n_bad++; $display("FAIL median_next_trig_%0d: got none want trig", i); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_trig_timing();
    test_echo();
    test_no_echo();
    test_long_echo();
    test_reset_mid();
`ifdef ULTRASONIC_RANGER_MEDIAN3_EN
    test_median();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
